nios2_mul_arbiter: RTL
======================

# nios2_mul_arbiter

Round-robin arbiter that shares one pipelined 32-bit multiplier cell (32×32 → low 32 bits, fixed input-to-result latency, no stall enable) among several requesters in the Nios II SoC. Accepts at most one operation per cycle and drives the cell's operand inputs. Tracks each in-flight operation's owner through a tag pipeline matched to the cell latency. Returns each registered result to the issuing requester.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- CELL_LAT, 1: cell latency in cycles, operands presented at edge N give a valid result after edge N+CELL_LAT, 1..4
- DATA_W, 32: operand/result width
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset; also fans out to the cell's clear
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  one-hot grant, asserted in the cycle the operation is accepted
- req_src1  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
- req_src2  in  NUM_REQ*DATA_W  packed operand B, same packing
- mul_src1  out  DATA_W  operand A to cell
- mul_src2  out  DATA_W  operand B to cell
- mul_result  in  DATA_W  cell result
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered
- rsp_result  out  DATA_W  shared result bus, registered, meaningful only when rsp_valid≠0
- issue_count  out  32  number of accepted operations since reset, wraps

## Operation
- Arbitration:
  - Each cycle, grant = first asserted req_valid bit searching upward (circular) from rr_ptr.
  - req_ready[grant] = 1 combinationally in that cycle; acceptance = req_valid & req_ready.
  - On acceptance, rr_ptr ← grant+1 mod NUM_REQ. No acceptance → rr_ptr holds.
- Operand mux:
  - mul_src1/mul_src2 = granted requester's operands.
  - When nothing is granted, they hold the last granted operands, to avoid toggling.
- Tag pipeline:
  - CELL_LAT stages of {valid, owner index}, shifting every cycle. There is no stall, because the cell enable is tied high.
  - Stage 0 loads {acceptance, grant}.
- Response:
  - When the last tag stage is valid: rsp_valid ← onehot(owner), rsp_result ← mul_result.
  - Otherwise rsp_valid ← 0 and rsp_result holds.
- Requesters cannot backpressure responses and must sample rsp_valid every cycle.
- Requesters may issue back-to-back. Responses return in issue order, globally and per requester.
- issue_count increments by 1 per acceptance and wraps 0xFFFFFFFF → 0.
- Arithmetic: the cell is unsigned and returns the low DATA_W bits; overflow is discarded silently. The arbiter passes data unmodified.

## Timing
- Reset values:
  - req_ready = 0 while reset is asserted.
  - rsp_valid = 0, rsp_result = 0, issue_count = 0.
  - rr_ptr = 0, all tag valids = 0, mul_src1/2 = 0.
- Latency: accept at edge N → rsp_valid high for exactly one cycle after edge N+CELL_LAT+1.
- Throughput: one operation per cycle sustained. Full bandwidth is shared fairly: with all NUM_REQ requesters active, each gets 1 of every NUM_REQ grants.
- Simultaneous events:
  - An acceptance and a response in the same cycle are independent.
  - A requester may be accepted in the same cycle its earlier response is delivered.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid is produced for them. The cell is cleared by the same reset.
- req_valid deasserted before grant: the request is withdrawn, with no side effects.

## Structure
- Shared package holds:
  - MUL_DATA_W = 32
  - MAX_REQ = 8
  - the tag typedef {logic valid; logic [2:0] owner}
- One natural sub-module: nios2_rr_arbiter (NUM_REQ request vector in, one-hot grant out, pointer update on accept). It is reusable for other shared units.
- The tag pipeline, operand mux, response register and counter stay in the top module.

## Test plan
- Reset release, single requester 0: 0x00000003 × 0x00000005 → rsp_valid=0001 and rsp_result=0x0000000F, CELL_LAT+1 cycles after accept; issue_count=1.
- All four requesters valid continuously for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; responses come back in the same order with the correct products; issue_count=8.
- Overflow: 0x00010000 × 0x00010000 → 0x00000000; 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- Requester 2 issues 3 back-to-back operations while the others are idle → accepted on 3 consecutive cycles; 3 consecutive rsp_valid=0100 pulses with the results in order.
- Assert reset while 2 operations are in flight → no rsp_valid after reset release; rr_ptr=0 and issue_count=0.
- Walk requester 1's req_valid 1→0 before grant (requester 0 holding the bus) → no grant to 1, no response to 1, issue_count unchanged for 1.

Source files
------------

// File: rtl/nios2_mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: data width, requester limit,
// in-flight tag type and round-robin pointer helper.
package nios2_mul_arbiter_pkg;

   localparam int MUL_DATA_W = 32;
   localparam int MAX_REQ    = 8;

   typedef struct packed {
      logic       valid;
      logic [2:0] owner;
   } mul_tag_t;

   // Circular increment of a requester index within 0..num_req-1.
   function automatic logic [2:0] rr_next(input logic [2:0] idx, input int num_req);
      return (int'(idx) == num_req - 1) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/nios2_mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: packed requests plus the
// shared registered response.
interface nios2_mul_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_src1;
   logic [NUM_REQ*DATA_W-1:0] req_src2;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_result;

   modport master (
      output req_valid, req_src1, req_src2,
      input  req_ready, rsp_valid, rsp_result
   );

   modport slave (
      input  req_valid, req_src1, req_src2,
      output req_ready, rsp_valid, rsp_result
   );
endinterface

// File: rtl/nios2_rr_arbiter.sv
// Generic round-robin arbiter: combinational one-hot grant searching upward
// from rr_ptr, pointer advances past the winner on accept.
module nios2_rr_arbiter
   import nios2_mul_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         grant_idx
);

   logic [2:0] rr_ptr_reg;
   logic       found;
   int         cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_reg) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && cand == j && req[j]) begin
               found     = 1'b1;
               grant_idx = 3'(j);
            end
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         grant[j] = found && (grant_idx == 3'(j));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_reg <= '0;
      end else if (accept) begin
         rr_ptr_reg <= rr_next(grant_idx, NUM_REQ);
      end
   end

endmodule

// File: rtl/nios2_mul_arbiter.sv
// Shares one pipelined multiplier cell among NUM_REQ requesters; owner tags
// ride alongside the cell stages so each result returns to its issuer.
module nios2_mul_arbiter
   import nios2_mul_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int CELL_LAT = 1,
   parameter int DATA_W   = MUL_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   nios2_mul_arbiter_if.slave  bus,
   output logic [DATA_W-1:0]   mul_src1,
   output logic [DATA_W-1:0]   mul_src2,
   input  logic [DATA_W-1:0]   mul_result,
   output logic [31:0]         issue_count
);

   logic [NUM_REQ-1:0] grant;
   logic [2:0]         grant_idx;
   logic               accept;
   logic [DATA_W-1:0]  src1_arr [NUM_REQ];
   logic [DATA_W-1:0]  src2_arr [NUM_REQ];
   logic [DATA_W-1:0]  sel_src1;
   logic [DATA_W-1:0]  sel_src2;
   logic [NUM_REQ-1:0] rsp_onehot;

   logic [DATA_W-1:0]  mul_src1_reg;
   logic [DATA_W-1:0]  mul_src2_reg;
   mul_tag_t           issue_tag_reg;
   mul_tag_t           tag_reg [CELL_LAT];
   logic [NUM_REQ-1:0] rsp_valid_reg;
   logic [DATA_W-1:0]  rsp_result_reg;
   logic [31:0]        issue_count_reg;

   nios2_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clk       (clk),
      .reset     (reset),
      .req       (bus.req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign bus.req_ready = reset ? '0 : grant;
   assign accept        = |(bus.req_valid & bus.req_ready);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign src1_arr[gi] = bus.req_src1[gi*DATA_W +: DATA_W];
         assign src2_arr[gi] = bus.req_src2[gi*DATA_W +: DATA_W];
      end
   endgenerate

   always_comb begin
      sel_src1   = '0;
      sel_src2   = '0;
      rsp_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_src1 = sel_src1 | src1_arr[i];
            sel_src2 = sel_src2 | src2_arr[i];
         end
         rsp_onehot[i] = (tag_reg[CELL_LAT-1].owner == 3'(i));
      end
   end

   // The operand register is the cell's input stage, so its companion tag
   // (issue_tag_reg) sits ahead of the CELL_LAT stages that shadow the cell.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_src1_reg    <= '0;
         mul_src2_reg    <= '0;
         issue_tag_reg   <= '0;
         for (int k = 0; k < CELL_LAT; k++) tag_reg[k] <= '0;
         rsp_valid_reg   <= '0;
         rsp_result_reg  <= '0;
         issue_count_reg <= '0;
      end else begin
         if (accept) begin
            mul_src1_reg    <= sel_src1;
            mul_src2_reg    <= sel_src2;
            issue_count_reg <= issue_count_reg + 32'd1;
         end
         issue_tag_reg.valid <= accept;
         issue_tag_reg.owner <= grant_idx;
         tag_reg[0]          <= issue_tag_reg;
         for (int k = 1; k < CELL_LAT; k++) tag_reg[k] <= tag_reg[k-1];
         if (tag_reg[CELL_LAT-1].valid) begin
            rsp_valid_reg  <= rsp_onehot;
            rsp_result_reg <= mul_result;
         end else begin
            rsp_valid_reg  <= '0;
         end
      end
   end

   assign mul_src1       = mul_src1_reg;
   assign mul_src2       = mul_src2_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_result = rsp_result_reg;
   assign issue_count    = issue_count_reg;

endmodule
